// File: rtl/usrt_pkg.sv
// Shared types and sizes for the USRT transmit scheduler.
package usrt_pkg;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned PTR_W  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_ARB,
        S_LOAD,
        S_WBUSY,
        S_WDONE,
        S_TAIL
    } state_t;

    // Index of the set bit in a one-hot requester vector.
    function automatic logic [PTR_W-1:0] onehot_idx(input logic [NREQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter4
    import usrt_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  winner_c,
    output logic             any_c
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        winner_c = '0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + PTR_W'(k);
            if (req[idx] && (winner_c == '0)) winner_c[idx] = 1'b1;
        end
    end

    assign any_c = |req;

endmodule

// File: rtl/usrt_tx_sched.sv
// Schedules requester bytes onto a USRT transmitter, framing each burst with RTS
// lead/tail time and watching the transmitter for a missing busy response.
module usrt_tx_sched
    import usrt_pkg::*;
#(
    parameter int unsigned RTS_LEAD = 16,
    parameter int unsigned RTS_TAIL = 4,
    parameter int unsigned BUSY_TO  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*BYTE_W-1:0] req_data,
    output logic [NREQ-1:0]        gnt,
    output logic [BYTE_W-1:0]      tx_data,
    output logic                   tx_load,
    input  logic                   tx_busy,
    output logic                   RTS,
    output logic                   err
);

    localparam int unsigned CNT_MAX = max3(RTS_LEAD, RTS_TAIL, BUSY_TO);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win;
    logic [CNT_W-1:0] cnt;

    logic [NREQ-1:0]   arb_win_c;
    logic              arb_any_c;
    logic [PTR_W-1:0]  arb_idx_c;
    logic [BYTE_W-1:0] win_byte_c;

    rr_arbiter4 u_arb (
        .req      (req),
        .ptr      (ptr),
        .winner_c (arb_win_c),
        .any_c    (arb_any_c)
    );

    assign arb_idx_c = onehot_idx(arb_win_c);

    always_comb begin
        win_byte_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx_c == PTR_W'(i)) win_byte_c = req_data[i*BYTE_W +: BYTE_W];
        end
    end

    // Burst sequencer; every output is a register updated on state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            win     <= '0;
            cnt     <= '0;
            RTS     <= 1'b0;
            gnt     <= '0;
            tx_load <= 1'b0;
            tx_data <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en && arb_any_c) begin
                        state <= S_LEAD;
                        RTS   <= 1'b1;
                        cnt   <= '0;
                    end
                end
                S_LEAD: begin
                    if (cnt == CNT_W'(RTS_LEAD - 1)) begin
                        state <= S_ARB;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_ARB: begin
                    // Requests may have vanished during the lead; close the burst then.
                    if (arb_any_c) begin
                        state   <= S_LOAD;
                        win     <= arb_idx_c;
                        gnt     <= arb_win_c;
                        tx_load <= 1'b1;
                        tx_data <= win_byte_c;
                    end else begin
                        state <= S_TAIL;
                        cnt   <= '0;
                    end
                end
                S_LOAD: begin
                    gnt     <= '0;
                    tx_load <= 1'b0;
                    ptr     <= win + PTR_W'(1);
                    cnt     <= CNT_W'(1);
                    state   <= S_WBUSY;
                end
                S_WBUSY: begin
                    // cnt holds cycles elapsed since the load pulse.
                    if (cnt == CNT_W'(BUSY_TO)) begin
                        err   <= 1'b0;
                        state <= S_TAIL;
                        cnt   <= '0;
                    end else if (tx_busy) begin
                        state <= S_WDONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(BUSY_TO - 1)) err <= 1'b1;
                    end
                end
                S_WDONE: begin
                    if (!tx_busy) begin
                        if (en && arb_any_c) begin
                            state <= S_ARB;
                        end else begin
                            state <= S_TAIL;
                            cnt   <= '0;
                        end
                    end
                end
                S_TAIL: begin
                    if (cnt == CNT_W'(RTS_TAIL - 1)) begin
                        state <= S_IDLE;
                        RTS   <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usrt_tx_sched.sv
// Bench for usrt_tx_sched: event-timed reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_usrt_tx_sched;

    localparam int RTS_LEAD = 16;
    localparam int RTS_TAIL = 4;
    localparam int BUSY_TO  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [7:0]  tx_data;
    logic        tx_load;
    logic        tx_busy = 1'b0;
    logic        RTS;
    logic        err;

    usrt_tx_sched #(.RTS_LEAD(RTS_LEAD), .RTS_TAIL(RTS_TAIL), .BUSY_TO(BUSY_TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_busy  (tx_busy),
        .RTS      (RTS),
        .err      (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Requesters: each holds req while it has posted bytes not yet granted.
    int         posted[4] = '{0, 0, 0, 0};
    int         served[4] = '{0, 0, 0, 0};
    logic [7:0] base[4]   = '{8'h00, 8'h00, 8'h00, 8'h00};

    always_comb begin
        req      = '0;
        req_data = '0;
        for (int i = 0; i < 4; i++) begin
            req[i]             = (posted[i] != served[i]);
            req_data[i*8 +: 8] = base[i] + 8'(served[i]);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (gnt[i]) served[i]++;
        end
    end

    // Transmitter: busy goes high two cycles after a load and stays high five cycles.
    bit xmit_on = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            if (tx_load && xmit_on) begin
                repeat (2) @(negedge clk);
                tx_busy = 1'b1;
                repeat (5) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    // Reference model: schedules events by clock-edge number.
    int         e = 0;
    int         arb_edge = -1, load_edge = -1, tail_drop = -1, k = 0, w = 0, ptr_m = 0;
    bit         watch_busy = 0, watch_fall = 0, rts_m = 0, found = 0;
    logic       x_load = 0, x_err = 0;
    logic [3:0] x_gnt = '0;
    logic [7:0] x_data = '0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                arb_edge = -1; tail_drop = -1; watch_busy = 0; watch_fall = 0;
                rts_m = 0; ptr_m = 0; x_load = 0; x_gnt = '0; x_data = '0; x_err = 0;
            end else begin
                e++;
                x_load = 0; x_gnt = '0; x_err = 0;
                if (!rts_m) begin
                    if (en && req != 0) begin
                        rts_m    = 1;
                        arb_edge = e + RTS_LEAD + 1;
                    end
                end else begin
                    if (e == tail_drop) begin
                        rts_m = 0; tail_drop = -1;
                    end
                    if (watch_fall && !tx_busy) begin
                        watch_fall = 0;
                        if (en && req != 0) arb_edge = e + 1;
                        else tail_drop = e + RTS_TAIL;
                    end
                    if (watch_busy) begin
                        k = e - load_edge;
                        if (k == BUSY_TO + 1) begin
                            watch_busy = 0; tail_drop = e + RTS_TAIL;
                        end else if (k >= 2) begin
                            if (tx_busy) begin
                                watch_busy = 0; watch_fall = 1;
                            end else if (k == BUSY_TO) begin
                                x_err = 1;
                            end
                        end
                    end
                    if (e == arb_edge) begin
                        arb_edge = -1;
                        found    = 0;
                        for (int j = 0; j < 4; j++) begin
                            if (!found && req[(ptr_m + j) % 4]) begin
                                found = 1; w = (ptr_m + j) % 4;
                            end
                        end
                        if (found) begin
                            x_load = 1; x_gnt = 4'(1 << w); x_data = req_data[w*8 +: 8];
                            ptr_m = (w + 1) % 4; load_edge = e; watch_busy = 1;
                        end else begin
                            tail_drop = e + RTS_TAIL;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model, plus an event log for the directed checks.
    int         rise_e = 0, fall_e = 0, busy_fall_e = 0, err_e = 0, rise_cnt = 0;
    logic       prev_rts = 0, prev_busy = 0;
    logic [3:0] gq[$];
    logic [7:0] dq[$];
    int         lq[$];

    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("rts", RTS, rts_m);
            chk("tx_load", tx_load, x_load);
            chk("gnt", gnt, x_gnt);
            chk("err", err, x_err);
            if (x_load || rst) chk("tx_data", tx_data, rst ? 8'h00 : x_data);
            if (RTS && !prev_rts) begin rise_e = e; rise_cnt++; end
            if (!RTS && prev_rts) fall_e = e;
            if (!tx_busy && prev_busy) busy_fall_e = e;
            if (err) err_e = e;
            if (tx_load) begin gq.push_back(gnt); dq.push_back(tx_data); lq.push_back(e); end
            prev_rts  = RTS;
            prev_busy = tx_busy;
        end
    end

    task automatic post(input int i, input logic [7:0] b, input int n);
        base[i]   = b - 8'(served[i]);
        posted[i] = served[i] + n;
    endtask

    task automatic wait_quiet(input string name);
        int  n  = 0;
        bit  ok = 0;
        while (n < 400 && !ok) begin
            @(posedge clk); #3; n++;
            if (n > 2 && !RTS && req == 0 && !tx_busy) ok = 1;
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_busy(input string name);
        int n  = 0;
        bit ok = 0;
        while (n < 200 && !ok) begin
            @(posedge clk); #3; n++;
            if (tx_busy) ok = 1;
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_rts_low(input string name);
        int n  = 0;
        bit ok = 0;
        while (n < 200 && !ok) begin
            @(posedge clk); #3; n++;
            if (!RTS) ok = 1;
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    int         q0, r0;
    logic [7:0] exp2[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [3:0] exp3g[3] = '{4'b1000, 4'b0001, 4'b1000};
    logic [7:0] exp3d[3] = '{8'h3C, 8'h0A, 8'h3D};

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rts", RTS, 1'b0);
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_load", tx_load, 1'b0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        en  = 1'b1;

        // Single byte from requester 2.
        @(negedge clk);
        q0 = dq.size();
        post(2, 8'hA5, 1);
        wait_quiet("t1_done");
        chk("t1_count", 32'(dq.size() - q0), 32'd1);
        if (dq.size() > q0) begin
            chk("t1_data", dq[q0], 8'hA5);
            chk("t1_gnt", gq[q0], 4'b0100);
            chk("t1_lead", 32'(lq[q0] - rise_e), 32'd17);
        end
        chk("t1_tail", 32'(fall_e - busy_fall_e), 32'd4);

        // All four requesters from pointer 0: one burst in index order.
        pulse_reset();
        q0 = dq.size(); r0 = rise_cnt;
        for (int i = 0; i < 4; i++) post(i, exp2[i], 1);
        wait_quiet("t2_done");
        chk("t2_count", 32'(dq.size() - q0), 32'd4);
        for (int i = 0; i < 4; i++)
            if (q0 + i < dq.size()) chk("t2_data", dq[q0 + i], exp2[i]);
        chk("t2_bursts", 32'(rise_cnt - r0), 32'd1);

        // Grant 3, then 1001 pending: pointer wraps to 0 before 3 again.
        @(negedge clk);
        q0 = dq.size(); r0 = rise_cnt;
        post(3, 8'h3C, 2);
        begin
            int n = 0;
            while (n < 100 && dq.size() == q0) begin @(posedge clk); #3; n++; end
        end
        @(negedge clk);
        post(0, 8'h0A, 1);
        wait_quiet("t3_done");
        chk("t3_count", 32'(dq.size() - q0), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (q0 + i < dq.size()) begin
                chk("t3_gnt", gq[q0 + i], exp3g[i]);
                chk("t3_data", dq[q0 + i], exp3d[i]);
            end
        end
        chk("t3_bursts", 32'(rise_cnt - r0), 32'd1);

        // Transmitter never goes busy: timeout error.
        @(negedge clk);
        xmit_on = 1'b0;
        q0 = dq.size();
        post(2, 8'h5A, 1);
        wait_quiet("t4_done");
        chk("t4_count", 32'(dq.size() - q0), 32'd1);
        if (dq.size() > q0) chk("t4_err_at", 32'(err_e - lq[q0]), 32'd8);
        chk("t4_tail", 32'(fall_e - err_e), 32'd5);
        xmit_on = 1'b1;

        // Enable dropped while waiting for busy to fall.
        @(negedge clk);
        q0 = dq.size();
        post(1, 8'h50, 2);
        wait_busy("t5_busy");
        @(negedge clk);
        en = 1'b0;
        wait_rts_low("t5_rts_low");
        repeat (6) @(negedge clk);
        chk("t5_count_off", 32'(dq.size() - q0), 32'd1);
        chk("t5_rts_off", RTS, 1'b0);
        en = 1'b1;
        wait_quiet("t5_done");
        chk("t5_count_on", 32'(dq.size() - q0), 32'd2);
        if (dq.size() > q0 + 1) chk("t5_data2", dq[q0 + 1], 8'h51);

        // Reset during a burst: outputs clear at once, pending byte served after fresh lead.
        @(negedge clk);
        q0 = dq.size();
        post(1, 8'h70, 2);
        wait_busy("t6_busy");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rts", RTS, 1'b0);
        chk("t6_gnt", gnt, 4'b0000);
        chk("t6_load", tx_load, 1'b0);
        chk("t6_data", tx_data, 8'h00);
        chk("t6_err", err, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_quiet("t6_done");
        chk("t6_count", 32'(dq.size() - q0), 32'd2);
        if (dq.size() > q0 + 1) begin
            chk("t6_data2", dq[q0 + 1], 8'h71);
            chk("t6_lead", 32'(lq[q0 + 1] - rise_e), 32'd17);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
